// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
//   Parametrised Mealy serial-pattern detector with a programmable pattern,
//   overlapping / non-overlapping match mode, input-valid qualifier and a
//   saturating match counter. The match output is asserted combinationally in
//   the same cycle as the bit that completes the pattern.
//
// Ports
//   clk          in   1          rising-edge clock
//   reset_n      in   1          asynchronous, active-low reset
//   enable       in   1          1 = detector running, 0 = idle (input ignored)
//   load         in   1          pulse: capture pattern_in/overlap, clear history/count
//   pattern_in   in   PATTERN_W  new pattern, MSB is the first bit received
//   overlap      in   1          mode captured on load (1 = overlapping)
//   in_valid     in   1          qualifies din
//   din          in   1          serial data bit
//   match        out  1          current din completes the pattern (combinational)
//   match_count  out  CNT_W      saturating match count since reset/load
//   count_sat    out  1          match_count is all ones
// -----------------------------------------------------------------------------
module seq_detector_param #(
    parameter int                   PATTERN_W       = 4,
    parameter logic [PATTERN_W-1:0] DEFAULT_PATTERN = 4'b1011,
    parameter logic                 DEFAULT_OVERLAP = 1'b1,
    parameter int                   CNT_W           = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 enable,
    input  logic                 load,
    input  logic [PATTERN_W-1:0] pattern_in,
    input  logic                 overlap,
    input  logic                 in_valid,
    input  logic                 din,
    output logic                 match,
    output logic [CNT_W-1:0]     match_count,
    output logic                 count_sat
);

    localparam int             HW       = PATTERN_W - 1;
    localparam int             FW       = $clog2(PATTERN_W);
    localparam logic [FW-1:0]  FILL_MAX = FW'(PATTERN_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_FILL = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [PATTERN_W-1:0]   pattern_q, pattern_d;
    logic                   overlap_q, overlap_d;
    logic [HW-1:0]          hist_q, hist_d;
    logic [FW-1:0]          fill_q, fill_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic                   count_sat_q, count_sat_d;

    logic                   accepted_s;
    logic [PATTERN_W-1:0]   window_s;
    logic [FW-1:0]          fill_inc_s;
    logic                   match_s;

    // Candidate window: stored history followed by the incoming bit. Its low
    // HW bits are the shifted history, which also covers PATTERN_W == 2.
    assign accepted_s = enable & in_valid & ~load;
    assign window_s   = {hist_q, din};
    assign fill_inc_s = (fill_q == FILL_MAX) ? FILL_MAX : (fill_q + FW'(1));
    assign match_s    = accepted_s & (state_q == ST_RUN) & (window_s == pattern_q);

    // Next-state, history, fill and counter update.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        overlap_d = overlap_q;
        hist_d    = hist_q;
        fill_d    = fill_q;
        count_d   = count_q;
        if (load) begin
            // Load wins over data; the din of this cycle is dropped.
            pattern_d = pattern_in;
            overlap_d = overlap;
            hist_d    = {HW{1'b0}};
            fill_d    = {FW{1'b0}};
            count_d   = {CNT_W{1'b0}};
            state_d   = enable ? ST_FILL : ST_IDLE;
        end else if (!enable) begin
            state_d = ST_IDLE;
            hist_d  = {HW{1'b0}};
            fill_d  = {FW{1'b0}};
        end else if (accepted_s) begin
            if (match_s && (count_q != CNT_MAX)) begin
                count_d = count_q + CNT_W'(1);
            end else begin
                count_d = count_q;
            end
            if (match_s && !overlap_q) begin
                // Non-overlapping: the completing bit starts nothing new.
                hist_d  = {HW{1'b0}};
                fill_d  = {FW{1'b0}};
                state_d = ST_FILL;
            end else begin
                hist_d  = window_s[HW-1:0];
                fill_d  = fill_inc_s;
                state_d = (fill_inc_s == FILL_MAX) ? ST_RUN : ST_FILL;
            end
        end else begin
            // Bubble: hold history; only leave IDLE now that enable is high.
            if (state_q == ST_IDLE) begin
                state_d = ST_FILL;
            end else begin
                state_d = state_q;
            end
        end
    end

    assign count_sat_d = (count_d == CNT_MAX);

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            pattern_q   <= DEFAULT_PATTERN;
            overlap_q   <= DEFAULT_OVERLAP;
            hist_q      <= {HW{1'b0}};
            fill_q      <= {FW{1'b0}};
            count_q     <= {CNT_W{1'b0}};
            count_sat_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pattern_q   <= pattern_d;
            overlap_q   <= overlap_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            count_q     <= count_d;
            count_sat_q <= count_sat_d;
        end
    end

    assign match       = match_s;
    assign match_count = count_q;
    assign count_sat   = count_sat_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// -----------------------------------------------------------------------------
// tb_seq_detector_param
//   Directed bench for seq_detector_param. Three instances share the control
//   and data inputs: a 4-bit / 8-bit-count detector (default 1011, overlap),
//   a 2-bit "two-ones" detector, and a 4-bit detector with a 2-bit counter.
// -----------------------------------------------------------------------------
module tb_seq_detector_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       load;
    logic       overlap;
    logic       in_valid;
    logic       din;
    logic [3:0] pattern_in4;
    logic [1:0] pattern_in2;
    logic [3:0] pattern_ins;

    logic       match4, match2, matchs;
    logic [7:0] count4, count2;
    logic [1:0] counts;
    logic       sat4, sat2, sats;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_detector_param #(.PATTERN_W(4), .DEFAULT_PATTERN(4'b1011),
                         .DEFAULT_OVERLAP(1'b1), .CNT_W(8)) dut4 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .pattern_in(pattern_in4), .overlap(overlap), .in_valid(in_valid),
        .din(din), .match(match4), .match_count(count4), .count_sat(sat4));

    seq_detector_param #(.PATTERN_W(2), .DEFAULT_PATTERN(2'b11),
                         .DEFAULT_OVERLAP(1'b1), .CNT_W(8)) dut2 (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .pattern_in(pattern_in2), .overlap(overlap), .in_valid(in_valid),
        .din(din), .match(match2), .match_count(count2), .count_sat(sat2));

    seq_detector_param #(.PATTERN_W(4), .DEFAULT_PATTERN(4'b1011),
                         .DEFAULT_OVERLAP(1'b0), .CNT_W(2)) duts (
        .clk(clk), .reset_n(reset_n), .enable(enable), .load(load),
        .pattern_in(pattern_ins), .overlap(overlap), .in_valid(in_valid),
        .din(din), .match(matchs), .match_count(counts), .count_sat(sats));

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; leave #1 for comb outputs.
    task automatic drive(input logic en, input logic v, input logic d);
        @(negedge clk);
        load     = 1'b0;
        enable   = en;
        in_valid = v;
        din      = d;
        #1;
    endtask

    task automatic do_load(input logic [3:0] p4, input logic [3:0] ps, input logic ov,
                           input logic v, input logic d);
        @(negedge clk);
        load        = 1'b1;
        pattern_in4 = p4;
        pattern_ins = ps;
        overlap     = ov;
        in_valid    = v;
        din         = d;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply n bits MSB-first and check the selected instance's match per bit.
    task automatic run_bits(input string tag, input int n, input logic [15:0] bits,
                            input logic [15:0] valid, input logic [15:0] exp, input int which);
        logic obs;
        for (int i = n - 1; i >= 0; i--) begin
            drive(1'b1, valid[i], bits[i]);
            case (which)
                0:       obs = match4;
                1:       obs = match2;
                default: obs = matchs;
            endcase
            chk($sformatf("%s_match[%0d]", tag, n - 1 - i), {7'd0, obs}, {7'd0, exp[i]});
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        load        = 1'b0;
        overlap     = 1'b1;
        in_valid    = 1'b0;
        din         = 1'b0;
        pattern_in4 = 4'b1011;
        pattern_in2 = 2'b11;
        pattern_ins = 4'b1011;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_match4", {7'd0, match4}, 8'd0);
        chk("rst_count4", count4, 8'd0);
        chk("rst_sat4", {7'd0, sat4}, 8'd0);
        chk("rst_counts", {6'd0, counts}, 8'd0);
        chk("rst_sats", {7'd0, sats}, 8'd0);

        @(negedge clk);
        reset_n = 1'b1;
        drive(1'b1, 1'b0, 1'b0);   // IDLE -> FILL

        // T2 legacy two-ones detector
        run_bits("t2", 5, 16'b01110, 16'h1F, 16'b00110, 1);
        tick();
        chk("t2_count", count2, 8'd2);

        // T3 overlapping 1010
        do_load(4'b1010, 4'b1011, 1'b1, 1'b0, 1'b0);
        tick();
        chk("t3a_count_load", count4, 8'd0);
        run_bits("t3a", 6, 16'b101010, 16'h3F, 16'b000101, 0);
        tick();
        chk("t3a_count", count4, 8'd2);

        // T3 non-overlapping 1010: load clears the count of 2
        do_load(4'b1010, 4'b1011, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t3b_count_load", count4, 8'd0);
        run_bits("t3b", 6, 16'b101010, 16'h3F, 16'b000100, 0);
        tick();
        chk("t3b_count", count4, 8'd1);

        // T4 bubbles: din=1 during bubbles must not be taken
        do_load(4'b1011, 4'b1011, 1'b1, 1'b0, 1'b0);
        tick();
        run_bits("t4", 6, 16'b101111, 16'b110101, 16'b000001, 0);
        tick();
        chk("t4_count", count4, 8'd1);

        // T5 saturation on the 2-bit counter, non-overlapping 1011
        do_load(4'b1011, 4'b1011, 1'b0, 1'b0, 1'b0);
        tick();
        for (int g = 0; g < 5; g++) begin
            run_bits($sformatf("t5g%0d", g), 4, 16'b1011, 16'hF, 16'b0001, 2);
            tick();
            chk($sformatf("t5_count%0d", g), {6'd0, counts}, (g >= 2) ? 8'd3 : 8'(g + 1));
            chk($sformatf("t5_sat%0d", g), {7'd0, sats}, (g >= 2) ? 8'd1 : 8'd0);
        end
        chk("t5_count4", count4, 8'd5);

        // T1 reset mid-stream: history 101 with din=1 would otherwise match
        run_bits("t1pre", 3, 16'b101, 16'h7, 16'b000, 0);
        @(negedge clk);
        reset_n  = 1'b0;
        in_valid = 1'b1;
        din      = 1'b1;
        #1;
        chk("t1_match4", {7'd0, match4}, 8'd0);
        chk("t1_count4", count4, 8'd0);
        chk("t1_counts", {6'd0, counts}, 8'd0);
        chk("t1_sats", {7'd0, sats}, 8'd0);
        @(negedge clk);
        reset_n  = 1'b1;
        in_valid = 1'b0;
        run_bits("t1post", 4, 16'b1011, 16'hF, 16'b0001, 0);

        // T6 load mid-stream with a completing din that must be discarded
        run_bits("t6pre", 3, 16'b101, 16'h7, 16'b000, 0);
        do_load(4'b1011, 4'b1011, 1'b0, 1'b1, 1'b1);
        chk("t6_load_match", {7'd0, match4}, 8'd0);
        run_bits("t6a", 1, 16'b1, 16'h1, 16'b0, 0);
        tick();
        chk("t6_count_load", count4, 8'd0);
        run_bits("t6b", 4, 16'b1011, 16'hF, 16'b0001, 0);
        tick();
        chk("t6_count", count4, 8'd1);

        // enable=0 clears history; count holds
        run_bits("enpre", 3, 16'b101, 16'h7, 16'b000, 0);
        drive(1'b0, 1'b1, 1'b1);
        chk("en_off_match", {7'd0, match4}, 8'd0);
        tick();
        chk("en_off_count", count4, 8'd1);
        run_bits("enpost", 4, 16'b1011, 16'hF, 16'b0001, 0);
        tick();
        chk("en_count", count4, 8'd2);

        drive(1'b1, 1'b0, 1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
